plot_clip_fifo: RTL
===================

// Module: plot_clip_fifo
// PURPOSE
//  Sits directly downstream of the reuleaux drawer: consumes its vga_x/vga_y/vga_colour/vga_plot stream,
//  discards off-screen pixels, buffers the rest in a FIFO and drains them to the VGA adapter under a
//  valid/ready handshake. Forwards the drawer's done only after every buffered pixel is delivered.
// PARAMETERS
//  DEPTH     16   FIFO entries (power of 2, >=2); entry = {x[7:0], y[6:0], colour[2:0]} = 18 bits
//  SCREEN_W  160  pixel is on-screen iff in_x < SCREEN_W
//  SCREEN_H  120  pixel is on-screen iff in_y < SCREEN_H
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  clear       in   1   synchronous flush: empties FIFO, zeroes counters, clears overflow, FSM->IDLE
//  in_x        in   8   drawer vga_x
//  in_y        in   7   drawer vga_y
//  in_colour   in   3   drawer vga_colour
//  in_plot     in   1   drawer vga_plot; one pixel per cycle while high
//  in_done     in   1   drawer done (level)
//  out_x       out  8   head-of-FIFO x
//  out_y       out  7   head-of-FIFO y
//  out_colour  out  3   head-of-FIFO colour
//  out_plot    out  1   head entry valid (FIFO non-empty)
//  out_ready   in   1   adapter accepts head this cycle
//  out_done    out  1   drawer done and FIFO fully drained
//  level       out  $clog2(DEPTH)+1  current occupancy
//  overflow    out  1   sticky: an on-screen pixel was lost because FIFO was full
//  pix_count   out  16  accepted (pushed) pixels, saturates at 16'hFFFF
//  clip_count  out  16  discarded off-screen pixels, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, level=0, out_plot=0, out_x/out_y/out_colour=0, out_done=0,
//   overflow=0, pix_count=0, clip_count=0, FSM=IDLE. clear=1 gives the same state at the next edge.
//  Push: in_plot=1 and on-screen -> write entry. Off-screen -> clip_count++, no write.
//  Pop: out_plot && out_ready at a rising edge removes head; next entry appears on the following cycle.
//  Latency: pixel pushed at edge N is on out_* with out_plot=1 after edge N (no combinational bypass).
//  Full (level==DEPTH): push with no pop -> pixel dropped, overflow<=1, pix_count unchanged.
//   Push with simultaneous pop while full -> both happen, level stays DEPTH, no overflow.
//  Empty: out_plot=0; out_ready ignored; out_x/y/colour hold last value.
//  Pointers wrap modulo DEPTH; level = wr-rd tracked with extra bit, never exceeds DEPTH.
//  Counters saturate; no wrap to 0.
//  FSM: IDLE --in_plot--> ACTIVE --in_done--> DRAIN --level==0--> DONE --!in_done--> IDLE.
//   IDLE --in_done && level==0--> DONE directly. out_done=1 only in DONE (registered).
//   in_plot pixels arriving in DRAIN/DONE are still pushed; in DONE a push returns FSM to DRAIN.
//  clear wins over any simultaneous push/pop in the same cycle.
//  Reset mid-operation: buffered pixels lost, no partial outputs after rst_n deasserts.
// CONFIGURATION
//  PLOT_DEDUP_EN defined: an on-screen pixel identical ({x,y,colour}) to the last pushed pixel is
//   discarded (counts in neither counter); the last-pushed record is invalidated by reset and clear.
//  PLOT_DEDUP_EN undefined: every on-screen pixel is pushed; no comparison logic.
// TESTING
//  1 Reset then push (30,20,010) with out_ready=1 -> next cycle out_plot=1,out_x=30,out_y=20; pix_count=1.
//  2 Push (160,5),(5,120),(159,119) -> clip_count=2, pix_count=1, only (159,119) appears at out_*.
//  3 out_ready=0, push 17 distinct on-screen pixels, DEPTH=16 -> level=16, overflow=1, pix_count=16;
//    then out_ready=1 -> 16 pixels emerge in push order, level=0.
//  4 Full FIFO, push+pop same cycle -> level stays 16, overflow stays 0, new pixel emerges last.
//  5 Push 5 pixels, assert in_done, out_ready toggling 1/0 -> out_done rises only after 5th pop.
//  6 Mid-stream clear=1 with level=7 -> next cycle level=0, out_plot=0, counters=0, overflow=0;
//    with PLOT_DEDUP_EN, two identical pushes -> pix_count=1.

Source files
------------

// File: rtl/plot_clip_fifo.sv
// plot_clip_fifo: screen-clipping pixel FIFO between the reuleaux drawer and the VGA adapter.
// Off-screen pixels are counted and discarded, on-screen pixels are buffered and drained under
// out_plot/out_ready, and the drawer's done is forwarded once the buffer has fully drained.
// Optional build macro PLOT_DEDUP_EN: an on-screen pixel equal to the last pushed pixel is dropped.
module plot_clip_fifo #(
   parameter int DEPTH    = 16,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [7:0]               in_x,
   input  logic [6:0]               in_y,
   input  logic [2:0]               in_colour,
   input  logic                     in_plot,
   input  logic                     in_done,
   output logic [7:0]               out_x,
   output logic [6:0]               out_y,
   output logic [2:0]               out_colour,
   output logic                     out_plot,
   input  logic                     out_ready,
   output logic                     out_done,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [15:0]              pix_count,
   output logic [15:0]              clip_count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam int          EW       = 18;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   state_t        state, state_next;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head, head_next, in_entry;
   logic [AW:0]   wr_ptr, rd_ptr, wr_next, rd_next, level_next;
   logic          on_screen, dup, full, pop, wr_en, drop;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign in_entry  = {in_x, in_y, in_colour};
   assign on_screen = ({24'd0, in_x} < 32'(SCREEN_W)) && ({25'd0, in_y} < 32'(SCREEN_H));

   assign level    = wr_ptr - rd_ptr;
   assign full     = (level == FULL_LVL);
   assign out_plot = (level != '0);
   assign pop      = out_plot && out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en    = in_plot && on_screen && !dup && (!full || pop);
   assign drop     = in_plot && on_screen && !dup && full && !pop;

   assign wr_next    = wr_ptr + {{AW{1'b0}}, wr_en};
   assign rd_next    = rd_ptr + {{AW{1'b0}}, pop};
   assign level_next = wr_next - rd_next;
   // The new head is the slot being written this edge only when it is also the write slot.
   assign head_next  = (wr_en && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) ? in_entry
                                                                      : mem[rd_next[AW-1:0]];

   assign out_x      = head[17:10];
   assign out_y      = head[9:3];
   assign out_colour = head[2:0];

`ifdef PLOT_DEDUP_EN
   logic          last_vld;
   logic [EW-1:0] last_entry;

   assign dup = last_vld && (last_entry == in_entry);

   // Validity of the last-pushed record; dropped by reset and clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_vld <= 1'b0;
      else if (clear)
         last_vld <= 1'b0;
      else if (wr_en)
         last_vld <= 1'b1;
   end

   // Remember the most recently pushed pixel.
   always_ff @(posedge clk) begin
      if (wr_en)
         last_entry <= in_entry;
   end
`else
   assign dup = 1'b0;
`endif

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (wr_en && !clear)
         mem[wr_ptr[AW-1:0]] <= in_entry;
   end

   // Pointers, head register, sticky overflow and saturating counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         head       <= '0;
         overflow   <= 1'b0;
         pix_count  <= '0;
         clip_count <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         head       <= '0;
         overflow   <= 1'b0;
         pix_count  <= '0;
         clip_count <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         if (level_next != '0)
            head <= head_next;
         if (drop)
            overflow <= 1'b1;
         if (wr_en)
            pix_count <= sat_inc(pix_count);
         if (in_plot && !on_screen)
            clip_count <= sat_inc(clip_count);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else if (clear)
         state <= IDLE;
      else
         state <= state_next;
   end

   // FSM next-state logic; DONE is only reached with nothing buffered and nothing arriving.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_plot)
               state_next = ACTIVE;
            else if (in_done && level == '0)
               state_next = DONE;
         end
         ACTIVE: begin
            if (in_done)
               state_next = DRAIN;
         end
         DRAIN: begin
            if (level == '0 && !wr_en)
               state_next = DONE;
         end
         DONE: begin
            if (wr_en)
               state_next = DRAIN;
            else if (!in_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      out_done = (state == DONE);
   end

endmodule
